// File: rtl/vram_line_arbiter.sv
// Read-modify-write arbiter for the single VRAM line port shared by the text-writer engines.
// Define VRAM_LINE_ARB_FIXED_PRIO_EN to use fixed priority (lowest index wins) instead of round-robin.
module vram_line_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 9,
   parameter int LINE_W  = 640,
   parameter int RD_LAT  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*LINE_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          vram_turn,
   output logic [LINE_W-1:0]           line_from_vram,
   output logic [NUM_REQ-1:0]          done,
   output logic [ADDR_W-1:0]           vram_addr,
   input  logic [LINE_W-1:0]           vram_rdata,
   output logic                        vram_we,
   output logic [LINE_W-1:0]           vram_wdata,
   output logic                        busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 2;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   RD_LAST  = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_RD   = 2'd1,
      ST_TURN = 2'd2,
      ST_WR   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   turn_q, turn_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0]    vram_addr_q, vram_addr_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic [LINE_W-1:0]    wdata_q, wdata_d;
   logic                 vram_we_q, vram_we_d;
   logic                 busy_q, busy_d;
   logic [IDX_W:0]       pick;

`ifdef VRAM_LINE_ARB_FIXED_PRIO_EN
   // Lowest set index wins; the descending scan lets the lowest index overwrite last.
   function automatic logic [IDX_W:0] pick_winner(input logic [NUM_REQ-1:0] r);
      logic [IDX_W:0] res;
      res = {(IDX_W+1){1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (r[k]) begin
            res = {1'b1, IDX_W'(k)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign pick = pick_winner(req);
`else
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   // First set bit after ptr (wrapping) wins; descending offset scan keeps the nearest one.
   function automatic logic [IDX_W:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   ptr);
      logic [IDX_W:0] res;
      int             idx;
      res = {(IDX_W+1){1'b0}};
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (r[idx]) begin
            res = {1'b1, IDX_W'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign pick = pick_winner(req, rr_ptr_q);
`endif

   // Next-state and output computation for the ARB -> RD -> TURN -> WR transaction
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      win_d       = win_q;
      rd_cnt_d    = rd_cnt_q;
      vram_addr_d = vram_addr_q;
      line_d      = line_q;
      wdata_d     = wdata_q;
      busy_d      = busy_q;
      turn_d      = {NUM_REQ{1'b0}};
      done_d      = {NUM_REQ{1'b0}};
      vram_we_d   = 1'b0;
`ifndef VRAM_LINE_ARB_FIXED_PRIO_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      case (state_q)
         ST_ARB: begin
            if (pick[IDX_W]) begin
               win_d       = pick[IDX_W-1:0];
               grant_d     = ONE_HOT0 << pick[IDX_W-1:0];
               vram_addr_d = req_addr[int'(pick[IDX_W-1:0])*ADDR_W +: ADDR_W];
`ifndef VRAM_LINE_ARB_FIXED_PRIO_EN
               rr_ptr_d    = pick[IDX_W-1:0];
`endif
               rd_cnt_d    = {CNT_W{1'b0}};
               busy_d      = 1'b1;
               state_d     = ST_RD;
            end else begin
               grant_d     = {NUM_REQ{1'b0}};
               busy_d      = 1'b0;
               state_d     = ST_ARB;
            end
         end
         ST_RD: begin
            if (rd_cnt_q == RD_LAST) begin
               line_d   = vram_rdata;
               turn_d   = grant_q;
               state_d  = ST_TURN;
            end else begin
               rd_cnt_d = rd_cnt_q + 2'd1;
               state_d  = ST_RD;
            end
         end
         ST_TURN: begin
            // A requester that dropped req during its turn forfeits the write-back.
            if (req[win_q] && req_we[win_q]) begin
               vram_we_d = 1'b1;
               wdata_d   = req_wdata[int'(win_q)*LINE_W +: LINE_W];
            end else begin
               vram_we_d = 1'b0;
            end
            done_d  = grant_q;
            state_d = ST_WR;
         end
         ST_WR: begin
            grant_d = {NUM_REQ{1'b0}};
            busy_d  = 1'b0;
            state_d = ST_ARB;
         end
         default: begin
            grant_d = {NUM_REQ{1'b0}};
            busy_d  = 1'b0;
            state_d = ST_ARB;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_ARB;
         grant_q     <= {NUM_REQ{1'b0}};
         turn_q      <= {NUM_REQ{1'b0}};
         done_q      <= {NUM_REQ{1'b0}};
         win_q       <= {IDX_W{1'b0}};
         rd_cnt_q    <= {CNT_W{1'b0}};
         vram_addr_q <= {ADDR_W{1'b0}};
         line_q      <= {LINE_W{1'b0}};
         wdata_q     <= {LINE_W{1'b0}};
         vram_we_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifndef VRAM_LINE_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         turn_q      <= turn_d;
         done_q      <= done_d;
         win_q       <= win_d;
         rd_cnt_q    <= rd_cnt_d;
         vram_addr_q <= vram_addr_d;
         line_q      <= line_d;
         wdata_q     <= wdata_d;
         vram_we_q   <= vram_we_d;
         busy_q      <= busy_d;
`ifndef VRAM_LINE_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign grant          = grant_q;
   assign vram_turn      = turn_q;
   assign done           = done_q;
   assign line_from_vram = line_q;
   assign vram_addr      = vram_addr_q;
   assign vram_we        = vram_we_q;
   assign vram_wdata     = wdata_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_vram_line_arbiter.sv
// Self-checking bench for vram_line_arbiter: vector table, done-driven scoreboard and corner sequences.
module tb_vram_line_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 9;
   localparam int LINE_W  = 640;
   localparam int NVEC    = 5;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [NUM_REQ-1:0]          req;
   logic [NUM_REQ*ADDR_W-1:0]   req_addr;
   logic [NUM_REQ-1:0]          req_we;
   logic [NUM_REQ*LINE_W-1:0]   req_wdata;
   logic [NUM_REQ-1:0]          grant;
   logic [NUM_REQ-1:0]          vram_turn;
   logic [LINE_W-1:0]           line_from_vram;
   logic [NUM_REQ-1:0]          done;
   logic [ADDR_W-1:0]           vram_addr;
   logic [LINE_W-1:0]           vram_rdata;
   logic                        vram_we;
   logic [LINE_W-1:0]           vram_wdata;
   logic                        busy;

   logic [LINE_W-1:0]           mem [0:511];
   logic [LINE_W-1:0]           wmask [NUM_REQ];

   typedef struct {
      int               idx;
      logic [ADDR_W-1:0] addr;
      logic             we;
      logic [LINE_W-1:0] wdata;
   } sb_t;

   typedef struct {
      int               idx;
      logic [ADDR_W-1:0] addr;
      logic             we;
      logic [LINE_W-1:0] wmask;
      logic [LINE_W-1:0] exp_turn;
      logic [LINE_W-1:0] exp_mem;
   } vec_t;

   sb_t  sb_q[$];
   sb_t  mon_e;
   vec_t vecs [NVEC];
   vec_t cur;
   int   n_vec = 0;
   int   n_err = 0;
   int   done_seen = 0;
   int   cyc;
   int   base;
   int   rr_order [8];
   int   hold_order [4];

   always #5 clk = ~clk;

   vram_line_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_we(req_we),
      .req_wdata(req_wdata), .grant(grant), .vram_turn(vram_turn),
      .line_from_vram(line_from_vram), .done(done), .vram_addr(vram_addr),
      .vram_rdata(vram_rdata), .vram_we(vram_we), .vram_wdata(vram_wdata), .busy(busy)
   );

   function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
      logic [31:0] w;
      if (a == 9'd100) return {LINE_W{1'b0}};
      w = {16'hC0DE, 7'd0, a};
      return {20{w}};
   endfunction

   function automatic logic [NUM_REQ-1:0] oh(input int i);
      return 4'b0001 << i;
   endfunction

   // VRAM stand-in: one-cycle read as seen from the registered address, write on vram_we
   assign vram_rdata = mem[vram_addr];
   initial for (int a = 0; a < 512; a++) mem[a] <= init_line(ADDR_W'(a));
   always @(posedge clk) if (vram_we) mem[vram_addr] <= vram_wdata;

   // Requesters modify the line combinationally from the broadcast read data
   always_comb begin
      req_wdata = {(NUM_REQ*LINE_W){1'b0}};
      for (int i = 0; i < NUM_REQ; i++) req_wdata[i*LINE_W +: LINE_W] = line_from_vram | wmask[i];
   end

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_until(input int target, input int budget, input bit drop, output int ncyc);
      ncyc = 0;
      while (done_seen < target && ncyc < budget) begin
         step();
         ncyc++;
         if (drop) req = req & ~done;
      end
      check("run_done_count", LINE_W'(done_seen), LINE_W'(target));
   endtask

   // Scoreboard: each done pulse retires the oldest expected transaction
   always @(negedge clk) begin
      if (rst_n && done != 4'b0000) begin
         done_seen++;
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=%0h, expected no transaction", done);
         end else begin
            mon_e = sb_q.pop_front();
            check("done_onehot", LINE_W'(done), LINE_W'(oh(mon_e.idx)));
            check("wr_we", LINE_W'(vram_we), LINE_W'(mon_e.we));
            check("wr_addr", LINE_W'(vram_addr), LINE_W'(mon_e.addr));
            if (mon_e.we) check("wr_data", vram_wdata, mon_e.wdata);
         end
      end
      if (rst_n && vram_we && done == 4'b0000) begin
         n_vec++;
         n_err++;
         $display("FAIL stray_write: got vram_we=1 at addr %0h, expected no write", vram_addr);
      end
   end

   initial begin
      vecs[0] = '{1, 9'd100, 1'b1, 640'hFF, '0, '0};
      vecs[1] = '{0, 9'd5,   1'b1, {20{32'hA5A5_0000}}, '0, '0};
      vecs[2] = '{3, 9'd511, 1'b0, {20{32'hFFFF_FFFF}}, '0, '0};
      vecs[3] = '{2, 9'd0,   1'b1, {LINE_W{1'b1}}, '0, '0};
      vecs[4] = '{1, 9'd300, 1'b1, {LINE_W{1'b0}}, '0, '0};
      for (int v = 0; v < NVEC; v++) begin
         vecs[v].exp_turn = init_line(vecs[v].addr);
         vecs[v].exp_mem  = vecs[v].we ? (vecs[v].exp_turn | vecs[v].wmask) : vecs[v].exp_turn;
      end
`ifdef VRAM_LINE_ARB_FIXED_PRIO_EN
      rr_order   = '{0, 0, 0, 0, 0, 0, 0, 0};
      hold_order = '{0, 0, 0, 0};
`else
      rr_order   = '{0, 1, 2, 3, 0, 1, 2, 3};
      hold_order = '{0, 3, 0, 3};
`endif

      rst_n = 1'b0;
      req = 4'b0000;
      req_we = 4'b0000;
      req_addr = {(NUM_REQ*ADDR_W){1'b0}};
      for (int i = 0; i < NUM_REQ; i++) wmask[i] = {LINE_W{1'b0}};
      step();
      step();
      rst_n = 1'b1;
      step();
      check("rst_grant", LINE_W'(grant), LINE_W'(4'b0000));
      check("rst_turn", LINE_W'(vram_turn), LINE_W'(4'b0000));
      check("rst_done", LINE_W'(done), LINE_W'(4'b0000));
      check("rst_we", LINE_W'(vram_we), LINE_W'(1'b0));
      check("rst_busy", LINE_W'(busy), LINE_W'(1'b0));
      check("rst_addr", LINE_W'(vram_addr), LINE_W'(9'd0));
      check("rst_line", line_from_vram, {LINE_W{1'b0}});
      check("rst_wdata", vram_wdata, {LINE_W{1'b0}});

      // Single-requester read-modify-write vectors
      for (int v = 0; v < NVEC; v++) begin
         cur = vecs[v];
         req_addr[cur.idx*ADDR_W +: ADDR_W] = cur.addr;
         req_we[cur.idx] = cur.we;
         wmask[cur.idx] = cur.wmask;
         req[cur.idx] = 1'b1;
         sb_q.push_back('{cur.idx, cur.addr, cur.we, cur.exp_mem});
         step();
         check("v_grant", LINE_W'(grant), LINE_W'(oh(cur.idx)));
         check("v_busy", LINE_W'(busy), LINE_W'(1'b1));
         check("v_addr", LINE_W'(vram_addr), LINE_W'(cur.addr));
         step();
         check("v_turn", LINE_W'(vram_turn), LINE_W'(oh(cur.idx)));
         check("v_line", line_from_vram, cur.exp_turn);
         step();
         req[cur.idx] = 1'b0;
         req_we[cur.idx] = 1'b0;
         step();
         check("v_idle_grant", LINE_W'(grant), LINE_W'(4'b0000));
         check("v_idle_busy", LINE_W'(busy), LINE_W'(1'b0));
         check("v_mem", mem[cur.addr], cur.exp_mem);
      end

      // All four requesters held for eight back-to-back transactions
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(200 + i);
      req_we = 4'b0000;
      req = 4'b1111;
      for (int k = 0; k < 8; k++)
         sb_q.push_back('{rr_order[k], ADDR_W'(200 + rr_order[k]), 1'b0, {LINE_W{1'b0}}});
      base = done_seen;
      run_until(base + 8, 64, 1'b0, cyc);
      check("rr_cycles", LINE_W'(cyc), LINE_W'(31));
      req = 4'b0000;
      step();
      check("rr_idle_busy", LINE_W'(busy), LINE_W'(1'b0));

      // Requester drops req during its turn: write suppressed, done still pulses
      req_addr[2*ADDR_W +: ADDR_W] = 9'd42;
      req_we[2] = 1'b1;
      wmask[2] = {LINE_W{1'b1}};
      req[2] = 1'b1;
      sb_q.push_back('{2, 9'd42, 1'b0, {LINE_W{1'b0}}});
      base = done_seen;
      cyc = 0;
      while (!vram_turn[2] && cyc < 8) begin
         step();
         cyc++;
      end
      check("abort_turn_lat", LINE_W'(cyc), LINE_W'(2));
      req[2] = 1'b0;
      run_until(base + 1, 8, 1'b1, cyc);
      req_we[2] = 1'b0;
      step();
      check("abort_mem", mem[42], init_line(9'd42));

      // Reset during the turn cycle aborts; requester 0 then wins first
      req_addr[3*ADDR_W +: ADDR_W] = 9'd77;
      req_we[3] = 1'b1;
      wmask[3] = {LINE_W{1'b1}};
      req[3] = 1'b1;
      cyc = 0;
      while (!vram_turn[3] && cyc < 8) begin
         step();
         cyc++;
      end
      check("rstmid_turn_lat", LINE_W'(cyc), LINE_W'(2));
      rst_n = 1'b0;
      req = 4'b0000;
      step();
      check("rstmid_we", LINE_W'(vram_we), LINE_W'(1'b0));
      check("rstmid_grant", LINE_W'(grant), LINE_W'(4'b0000));
      check("rstmid_busy", LINE_W'(busy), LINE_W'(1'b0));
      check("rstmid_done", LINE_W'(done), LINE_W'(4'b0000));
      check("rstmid_line", line_from_vram, {LINE_W{1'b0}});
      rst_n = 1'b1;
      req_we = 4'b0000;
      req_addr[0*ADDR_W +: ADDR_W] = 9'd10;
      req_addr[3*ADDR_W +: ADDR_W] = 9'd20;
      req = 4'b1001;
      for (int k = 0; k < 4; k++)
         sb_q.push_back('{hold_order[k], (hold_order[k] == 0) ? 9'd10 : 9'd20, 1'b0, {LINE_W{1'b0}}});
      base = done_seen;
      run_until(base + 4, 40, 1'b0, cyc);
      check("hold_cycles", LINE_W'(cyc), LINE_W'(15));
      req[0] = 1'b0;
      sb_q.push_back('{3, 9'd20, 1'b0, {LINE_W{1'b0}}});
      run_until(base + 5, 16, 1'b1, cyc);
      req = 4'b0000;
      step();
      check("rstmid_mem", mem[77], init_line(9'd77));
      check("sb_empty", LINE_W'(sb_q.size()), LINE_W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vram_line_arbiter.md
Name: vram_line_arbiter

Overview:
- Shares the single VRAM line port (640-bit lines, 9-bit line address) between several text-writer engines, e.g. the pipeline-instruction display and the register display.
- Each winning requester gets one read-modify-write transaction:
  - the line is read;
  - the requester receives a one-cycle vram_turn strobe with the line;
  - the modified line is optionally written back.
- Sits between the letter writers and the VRAM block RAM. It is the sole driver of the VRAM write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 9, VRAM line address width
- LINE_W, 640, VRAM line width in bits (one pixel per bit)
- RD_LAT, 1, VRAM read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester transaction request, level
- req_addr  in  NUM_REQ*ADDR_W  flattened line addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_we  in  NUM_REQ  write-back enable, sampled only in TURN
- req_wdata  in  NUM_REQ*LINE_W  flattened modified lines, sampled only in TURN
- grant  out  NUM_REQ  one-hot owner of the current transaction
- vram_turn  out  NUM_REQ  one-hot one-cycle strobe; line_from_vram valid
- line_from_vram  out  LINE_W  captured read line, broadcast to all requesters
- done  out  NUM_REQ  one-hot one-cycle pulse at transaction end
- vram_addr  out  ADDR_W  VRAM line address
- vram_rdata  in  LINE_W  VRAM read data, RD_LAT cycles after vram_addr
- vram_we  out  1  VRAM write strobe
- vram_wdata  out  LINE_W  VRAM write data
- busy  out  1  transaction in progress

Behaviour:
- Reset: all of the following cleared on the clock edge with rst_n=0, including mid-transaction:
  - grant, vram_turn, done, vram_we, busy = 0;
  - vram_addr, vram_wdata, line_from_vram = 0;
  - state = ARB; rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - A reset during RD, TURN or WR aborts the transaction; no VRAM write is issued.
- FSM: ARB -> RD -> TURN -> WR -> ARB.
- ARB:
  - If any req is high, select the winner by round-robin: search i = rr_ptr+1 .. rr_ptr+NUM_REQ, modulo NUM_REQ; first set bit wins.
  - Register grant, latch vram_addr <= req_addr[winner], set rr_ptr <= winner, set busy=1, go to RD.
  - With no req: stay in ARB, all outputs idle.
- RD:
  - Hold vram_addr.
  - Count RD_LAT cycles, then capture vram_rdata into line_from_vram and go to TURN.
- TURN: exactly one cycle.
  - vram_turn[winner]=1.
  - line_from_vram stays stable from TURN until the next RD capture.
  - At the end of the cycle, sample req_we[winner] and req_wdata[winner]; req_wdata may be combinational from line_from_vram.
  - If req[winner]=0 in TURN, the write is suppressed (abort).
- WR: one cycle.
  - If write was sampled: vram_we=1, vram_wdata = sampled data, vram_addr unchanged.
  - Otherwise vram_we=0.
  - done[winner]=1 in this cycle.
  - Next state is ARB; grant and busy clear on entry to ARB.
- Timing: transaction length is 3+RD_LAT cycles; with RD_LAT=1, a request seen in ARB at cycle 0 gives turn at cycle 2, write at cycle 3, next grant possible at cycle 4.
- Back-to-back: no dead cycles beyond ARB; the ARB cycle is the single arbitration cycle.
- Fairness: a requester holding req continuously waits at most NUM_REQ-1 transactions.
- Simultaneous events:
  - req changes during RD/TURN/WR do not alter grant.
  - A new req from the current winner is considered only after all others, via rr_ptr.
- Write data: vram_wdata holds its last value when vram_we=0.
- Addressing: req_addr values above the VRAM depth pass through unchanged; bounds checking belongs to the requester.

Optional Feature:
- VRAM_LINE_ARB_FIXED_PRIO_EN:
  - Defined: ARB uses fixed priority, lowest index wins; rr_ptr is not implemented. Requester 0 (pipeline display) can starve the others.
  - Undefined (default): round-robin as above.
  - All other timing is identical in both modes.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then idle -> grant=0, vram_we=0, busy=0, line_from_vram=0, state ARB.
- Single RMW, RD_LAT=1, mem[100]=all zeros:
  - Stimulus: req[1]=1, addr=100, we=1 in TURN, wdata=line_from_vram | 640'hFF.
  - Response: vram_turn[1] at cycle 2; vram_we at cycle 3 with addr 100; then mem[100]=640'hFF and done[1] pulses at cycle 3.
- Round-robin: all four req held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3, each transaction 4 cycles.
- Abort: req[2] dropped in the TURN cycle with req_we=1 -> vram_we stays 0, mem unchanged, done[2] still pulses.
- Reset mid-transaction: rst_n=0 in the TURN cycle -> next cycle no vram_we, grant=0, and requester 0 wins the next arbitration.
- Fixed priority (VRAM_LINE_ARB_FIXED_PRIO_EN defined): req[0] and req[3] held high -> requester 0 granted every transaction; requester 3 never granted until req[0] drops.
